// File: rtl/ysyx_220053_axi_bridge_if.sv
// AXI4 master-side bus between ysyx_220053_axi_bridge and the memory/device fabric.
// Carries the five AXI channels: AW, W, B, AR and R. The data bus is 64 bits wide.
//   master modport: the bridge drives the valid/payload signals and the B/R ready signals.
//   slave modport : the fabric drives the address/write ready signals and the B/R responses.
interface ysyx_220053_axi_bridge_if #(
    parameter int unsigned AXI_ADDR_W = 32
);
    logic                  axi_awvalid;
    logic [AXI_ADDR_W-1:0] axi_awaddr;
    logic [3:0]            axi_awid;
    logic [7:0]            axi_awlen;
    logic [2:0]            axi_awsize;
    logic [1:0]            axi_awburst;
    logic                  axi_awready;

    logic                  axi_wvalid;
    logic [63:0]           axi_wdata;
    logic [7:0]            axi_wstrb;
    logic                  axi_wlast;
    logic                  axi_wready;

    logic                  axi_bvalid;
    logic [1:0]            axi_bresp;
    logic                  axi_bready;

    logic                  axi_arvalid;
    logic [AXI_ADDR_W-1:0] axi_araddr;
    logic [3:0]            axi_arid;
    logic [7:0]            axi_arlen;
    logic [2:0]            axi_arsize;
    logic [1:0]            axi_arburst;
    logic                  axi_arready;

    logic                  axi_rvalid;
    logic [63:0]           axi_rdata;
    logic [1:0]            axi_rresp;
    logic                  axi_rlast;
    logic                  axi_rready;

    modport master (
        output axi_awvalid, axi_awaddr, axi_awid, axi_awlen, axi_awsize, axi_awburst,
        input  axi_awready,
        output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
        input  axi_wready,
        input  axi_bvalid, axi_bresp,
        output axi_bready,
        output axi_arvalid, axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst,
        input  axi_arready,
        input  axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
        output axi_rready
    );

    modport slave (
        input  axi_awvalid, axi_awaddr, axi_awid, axi_awlen, axi_awsize, axi_awburst,
        output axi_awready,
        input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
        output axi_wready,
        output axi_bvalid, axi_bresp,
        input  axi_bready,
        input  axi_arvalid, axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst,
        output axi_arready,
        output axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
        input  axi_rready
    );
endinterface

// File: rtl/ysyx_220053_axi_bridge.sv
// Converts the cache arbiter's single-request memory interface into AXI4 master transactions.
// Cacheable requests move one 128-bit line as a 2-beat INCR burst. Device requests move a
// single 64-bit beat with a byte strobe. Completion goes back to the arbiter over a 4-phase
// valid/ready handshake.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   rw_addr_i       request byte address (low AXI_ADDR_W bits are driven out)
//   rw_req_i        1 = write, 0 = read
//   rw_valid_i      request valid, held by the requester until rw_ready_o is seen
//   rw_w_data_i     write line; device writes use [63:0]
//   rw_size_i       device byte strobe; ignored for line accesses
//   rw_dev_i        1 = device single beat, 0 = cache line burst
//   data_read_o     registered read result
//   rw_ready_o      transaction complete
//   err_o           sticky AXI error flag
//   axi             AXI4 master bus (master modport)
// Build option: define YSYX_220053_AXI_RESP_CHECK_EN to make err_o record non-OKAY
// rresp/bresp and rlast misplacement; when undefined err_o is tied low.
module ysyx_220053_axi_bridge #(
    parameter int unsigned AXI_ADDR_W = 32,
    parameter logic [3:0]  AXI_ID     = 4'd0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [63:0]             rw_addr_i,
    input  logic                    rw_req_i,
    input  logic                    rw_valid_i,
    input  logic [127:0]            rw_w_data_i,
    input  logic [7:0]              rw_size_i,
    input  logic                    rw_dev_i,
    output logic [127:0]            data_read_o,
    output logic                    rw_ready_o,
    output logic                    err_o,
    ysyx_220053_axi_bridge_if.master axi
);
    typedef enum logic [2:0] {
        StIdle, StRaddr, StRdata, StWaddr, StWdata, StWresp, StDone
    } state_e;

    localparam logic [AXI_ADDR_W-1:0] LineMask = ~AXI_ADDR_W'(15);
    localparam logic [AXI_ADDR_W-1:0] DevMask  = ~AXI_ADDR_W'(7);

    state_e                state_q, state_d;
    logic [AXI_ADDR_W-1:0] addr_q, addr_d;
    logic [127:0]          wline_q, wline_d;
    logic [7:0]            strb_q, strb_d;
    logic                  dev_q, dev_d;
    logic                  cnt_q, cnt_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic [63:0]           wdata_q, wdata_d;
    logic [7:0]            wstrb_q, wstrb_d;
    logic                  wlast_q, wlast_d;
    logic                  bready_q, bready_d;
    logic [127:0]          data_q, data_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic                  last_beat;

    // Upper address bits beyond the AXI width are intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^rw_addr_i;

    // Device accesses are single beats (len 0); lines finish on the second beat.
    assign last_beat = dev_q | cnt_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wline_d   = wline_q;
        strb_d    = strb_q;
        dev_d     = dev_q;
        cnt_d     = cnt_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wlast_d   = wlast_q;
        bready_d  = bready_q;
        data_d    = data_q;
        unique case (state_q)
            StIdle: begin
                if (rw_valid_i) begin
                    addr_d  = rw_addr_i[AXI_ADDR_W-1:0] & (rw_dev_i ? DevMask : LineMask);
                    wline_d = rw_w_data_i;
                    strb_d  = rw_size_i;
                    dev_d   = rw_dev_i;
                    cnt_d   = 1'b0;
                    if (rw_req_i) begin
                        awvalid_d = 1'b1;
                        state_d   = StWaddr;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = StRaddr;
                    end
                end
            end
            StRaddr: begin
                if (axi.axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdata;
                end
            end
            StRdata: begin
                if (axi.axi_rvalid) begin
                    if (cnt_q) begin
                        data_d[127:64] = axi.axi_rdata;
                    end else begin
                        data_d[63:0] = axi.axi_rdata;
                        if (dev_q) data_d[127:64] = 64'h0;
                    end
                    if (last_beat) begin
                        rready_d = 1'b0;
                        cnt_d    = 1'b0;
                        state_d  = StDone;
                    end else begin
                        cnt_d = 1'b1;
                    end
                end
            end
            StWaddr: begin
                // W only starts once AW has been accepted.
                if (axi.axi_awready) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    wdata_d   = wline_q[63:0];
                    wstrb_d   = dev_q ? strb_q : 8'hFF;
                    wlast_d   = dev_q;
                    state_d   = StWdata;
                end
            end
            StWdata: begin
                if (axi.axi_wready) begin
                    if (wlast_q) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        bready_d = 1'b1;
                        cnt_d    = 1'b0;
                        state_d  = StWresp;
                    end else begin
                        cnt_d   = 1'b1;
                        wdata_d = wline_q[127:64];
                        wlast_d = 1'b1;
                    end
                end
            end
            StWresp: begin
                if (axi.axi_bvalid) begin
                    bready_d = 1'b0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (!rw_valid_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Completion is reported one cycle after entering DONE and only while the
        // requester still holds valid; dropping valid returns the bridge to IDLE.
        ready_d = (state_q == StDone) && rw_valid_i;
    end

`ifdef YSYX_220053_AXI_RESP_CHECK_EN
    always_comb begin
        err_d = err_q;
        if (state_q == StRdata && axi.axi_rvalid &&
            (axi.axi_rresp != 2'b00 || axi.axi_rlast != last_beat)) begin
            err_d = 1'b1;
        end
        if (state_q == StWresp && axi.axi_bvalid && axi.axi_bresp != 2'b00) begin
            err_d = 1'b1;
        end
    end
`else
    assign err_d = 1'b0;
    logic unused_resp;
    assign unused_resp = ^{axi.axi_rresp, axi.axi_bresp, axi.axi_rlast};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wline_q   <= '0;
            strb_q    <= '0;
            dev_q     <= 1'b0;
            cnt_q     <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wline_q   <= wline_d;
            strb_q    <= strb_d;
            dev_q     <= dev_d;
            cnt_q     <= cnt_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wlast_q   <= wlast_d;
            bready_q  <= bready_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    assign axi.axi_awvalid = awvalid_q;
    assign axi.axi_awaddr  = addr_q;
    assign axi.axi_awid    = AXI_ID;
    assign axi.axi_awlen   = dev_q ? 8'd0 : 8'd1;
    assign axi.axi_awsize  = 3'd3;
    assign axi.axi_awburst = 2'b01;
    assign axi.axi_wvalid  = wvalid_q;
    assign axi.axi_wdata   = wdata_q;
    assign axi.axi_wstrb   = wstrb_q;
    assign axi.axi_wlast   = wlast_q;
    assign axi.axi_bready  = bready_q;
    assign axi.axi_arvalid = arvalid_q;
    assign axi.axi_araddr  = addr_q;
    assign axi.axi_arid    = AXI_ID;
    assign axi.axi_arlen   = dev_q ? 8'd0 : 8'd1;
    assign axi.axi_arsize  = 3'd3;
    assign axi.axi_arburst = 2'b01;
    assign axi.axi_rready  = rready_q;

    assign data_read_o = data_q;
    assign rw_ready_o  = ready_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_ysyx_220053_axi_bridge.sv
// Self-checking bench for ysyx_220053_axi_bridge: directed scenarios plus randomized
// transactions, checked against a transaction-level model of the bridge.
module tb_ysyx_220053_axi_bridge;
`ifdef YSYX_220053_AXI_RESP_CHECK_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  rw_addr;
    logic         rw_req;
    logic         rw_valid;
    logic [127:0] rw_w_data;
    logic [7:0]   rw_size;
    logic         rw_dev;
    logic [127:0] data_read;
    logic         rw_ready;
    logic         err;

    ysyx_220053_axi_bridge_if #(.AXI_ADDR_W(32)) axi ();

    ysyx_220053_axi_bridge #(.AXI_ADDR_W(32), .AXI_ID(4'd0)) dut (
        .clk         (clk),
        .rst         (rst),
        .rw_addr_i   (rw_addr),
        .rw_req_i    (rw_req),
        .rw_valid_i  (rw_valid),
        .rw_w_data_i (rw_w_data),
        .rw_size_i   (rw_size),
        .rw_dev_i    (rw_dev),
        .data_read_o (data_read),
        .rw_ready_o  (rw_ready),
        .err_o       (err),
        .axi         (axi)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           vecs = 0;
    int           miscompares = 0;
    int unsigned  t0;
    logic [127:0] m_data = '0;
    logic         m_err = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int s);
        case (s)
            0:       return axi.axi_arvalid;
            1:       return axi.axi_awvalid;
            2:       return axi.axi_wvalid;
            3:       return axi.axi_bready;
            4:       return rw_ready;
            default: return 1'b0;
        endcase
    endfunction

    // Polls at negedges with a cycle budget; an expired budget counts as a miscompare.
    task automatic wait_for(input string tag, input int s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (sig(s)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            vecs++;
            miscompares++;
            $error("FAIL timeout_%s: observed 0 expected 1", tag);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [63:0] a, input logic dev);
        return a[31:0] & (dev ? 32'hFFFF_FFF8 : 32'hFFFF_FFF0);
    endfunction

    task automatic issue(input logic req, input logic dev, input logic [63:0] a,
                         input logic [127:0] wd, input logic [7:0] sz);
        rw_valid  = 1'b1;
        rw_req    = req;
        rw_dev    = dev;
        rw_addr   = a;
        rw_w_data = wd;
        rw_size   = sz;
        t0        = cyc + 1;
    endtask

    // Acts as the read slave; delivers up to 'stop' beats and updates the model on completion.
    task automatic serve_read(input logic dev, input logic [63:0] a, input logic [63:0] b0,
                              input logic [63:0] b1, input int ad, input int rd,
                              input logic [1:0] resp, input int stop);
        bit          ok;
        int          nb;
        logic [63:0] beat [2];
        nb      = dev ? 1 : 2;
        beat[0] = b0;
        beat[1] = b1;
        wait_for("arvalid", 0, ok);
        chk("araddr", axi.axi_araddr, exp_addr(a, dev));
        chk("arlen", axi.axi_arlen, dev ? 8'd0 : 8'd1);
        chk("arsize", axi.axi_arsize, 3'd3);
        chk("arburst", axi.axi_arburst, 2'b01);
        chk("arid", axi.axi_arid, 4'd0);
        repeat (ad) begin
            @(negedge clk);
            chk("arvalid_hold", axi.axi_arvalid, 1'b1);
        end
        axi.axi_arready = 1'b1;
        @(negedge clk);
        axi.axi_arready = 1'b0;
        chk("arvalid_drop", axi.axi_arvalid, 1'b0);
        for (int b = 0; b < nb && b < stop; b++) begin
            repeat (rd) begin
                chk("rready_wait", axi.axi_rready, 1'b1);
                @(negedge clk);
            end
            axi.axi_rvalid = 1'b1;
            axi.axi_rdata  = beat[b];
            axi.axi_rlast  = (b == nb - 1);
            axi.axi_rresp  = resp;
            chk("rready", axi.axi_rready, 1'b1);
            @(negedge clk);
            axi.axi_rvalid = 1'b0;
            axi.axi_rlast  = 1'b0;
            axi.axi_rresp  = 2'b00;
        end
        if (stop >= nb) begin
            m_data = dev ? {64'h0, beat[0]} : {beat[1], beat[0]};
            if (resp != 2'b00) m_err = m_err | ErrEn;
        end
    endtask

    // Acts as the write slave; checks AW-before-W ordering, beat contents and one B handshake.
    task automatic serve_write(input logic dev, input logic [63:0] a, input logic [127:0] wd,
                               input logic [7:0] sz, input int ad, input bit tog,
                               input logic [1:0] resp);
        bit ok;
        int nb;
        nb = dev ? 1 : 2;
        wait_for("awvalid", 1, ok);
        chk("awaddr", axi.axi_awaddr, exp_addr(a, dev));
        chk("awlen", axi.axi_awlen, dev ? 8'd0 : 8'd1);
        chk("awsize", axi.axi_awsize, 3'd3);
        chk("awburst", axi.axi_awburst, 2'b01);
        chk("awid", axi.axi_awid, 4'd0);
        repeat (ad) begin
            chk("w_before_aw", axi.axi_wvalid, 1'b0);
            @(negedge clk);
            chk("awvalid_hold", axi.axi_awvalid, 1'b1);
        end
        axi.axi_awready = 1'b1;
        chk("w_before_aw", axi.axi_wvalid, 1'b0);
        @(negedge clk);
        axi.axi_awready = 1'b0;
        for (int b = 0; b < nb; b++) begin
            wait_for("wvalid", 2, ok);
            if (tog) begin
                axi.axi_wready = 1'b0;
                @(negedge clk);
                chk("wvalid_hold", axi.axi_wvalid, 1'b1);
            end
            axi.axi_wready = 1'b1;
            chk("wdata", axi.axi_wdata, (b == 0) ? wd[63:0] : wd[127:64]);
            chk("wstrb", axi.axi_wstrb, dev ? sz : 8'hFF);
            chk("wlast", axi.axi_wlast, b == nb - 1);
            @(negedge clk);
            axi.axi_wready = 1'b0;
        end
        chk("wvalid_end", axi.axi_wvalid, 1'b0);
        wait_for("bready", 3, ok);
        axi.axi_bvalid = 1'b1;
        axi.axi_bresp  = resp;
        @(negedge clk);
        axi.axi_bvalid = 1'b0;
        axi.axi_bresp  = 2'b00;
        chk("bready_once", axi.axi_bready, 1'b0);
        if (resp != 2'b00) m_err = m_err | ErrEn;
    endtask

    task automatic finish_txn(input int lat);
        bit ok;
        wait_for("rw_ready", 4, ok);
        if (ok && lat >= 0) chk("latency", cyc - t0, lat);
        chk("data_read", data_read, m_data);
        chk("err", err, m_err);
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk("ready_hold", rw_ready, 1'b1);
        end
        rw_valid = 1'b0;
        @(negedge clk);
        chk("ready_drop", rw_ready, 1'b0);
    endtask

    task automatic run_txn(input logic req, input logic dev, input logic [63:0] a,
                           input logic [127:0] wd, input logic [7:0] sz, input logic [63:0] b0,
                           input logic [63:0] b1, input int ad, input int rd, input bit tog,
                           input logic [1:0] resp, input int lat);
        issue(req, dev, a, wd, sz);
        if (req) serve_write(dev, a, wd, sz, ad, tog, resp);
        else serve_read(dev, a, b0, b1, ad, rd, resp, 2);
        finish_txn(lat);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_arvalid"}, axi.axi_arvalid, 1'b0);
        chk({tag, "_rready"}, axi.axi_rready, 1'b0);
        chk({tag, "_awvalid"}, axi.axi_awvalid, 1'b0);
        chk({tag, "_wvalid"}, axi.axi_wvalid, 1'b0);
        chk({tag, "_bready"}, axi.axi_bready, 1'b0);
        chk({tag, "_rw_ready"}, rw_ready, 1'b0);
        chk({tag, "_err"}, err, m_err);
        chk({tag, "_data"}, data_read, m_data);
    endtask

    logic [63:0]  r_addr;
    logic [127:0] r_wd;
    logic         r_req, r_dev;
    int           r_ad, r_rd, r_lat;
    bit           r_tog, r_zw;

    initial begin
        rst = 1'b1;
        rw_valid = 1'b0; rw_req = 1'b0; rw_dev = 1'b0;
        rw_addr = '0; rw_w_data = '0; rw_size = '0;
        axi.axi_awready = 1'b0; axi.axi_wready = 1'b0;
        axi.axi_bvalid = 1'b0; axi.axi_bresp = 2'b00;
        axi.axi_arready = 1'b0; axi.axi_rvalid = 1'b0;
        axi.axi_rdata = '0; axi.axi_rresp = 2'b00; axi.axi_rlast = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;

        // Line read, zero-wait slave.
        run_txn(1'b0, 1'b0, 64'h0000_0000_8000_0018, '0, 8'h00,
                64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 0, 0, 1'b0, 2'b00, 4);
        chk("line_read_value", data_read,
            128'h2222_2222_2222_2222_1111_1111_1111_1111);

        // Device write, single strobed beat.
        run_txn(1'b1, 1'b1, 64'h0000_0000_A000_03F8, 128'hDEAD_BEEF, 8'h0F,
                '0, '0, 0, 0, 1'b0, 2'b00, -1);

        // Line write with slow AW and toggling wready.
        run_txn(1'b1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                8'h00, '0, '0, 3, 0, 1'b1, 2'b00, -1);

        // Device read with slow rvalid.
        run_txn(1'b0, 1'b1, {$urandom, $urandom}, '0, 8'h00, {$urandom, $urandom},
                {$urandom, $urandom}, 0, 5, 1'b0, 2'b00, -1);
        chk("dev_read_upper", data_read[127:64], 64'h0);

        // Reset in RDATA after the first beat of a line read.
        issue(1'b0, 1'b0, 64'h8000_1000, '0, 8'h00);
        serve_read(1'b0, 64'h8000_1000, {$urandom, $urandom}, {$urandom, $urandom},
                   0, 0, 2'b00, 1);
        rst = 1'b1;
        rw_valid = 1'b0;
        @(negedge clk);
        m_data = '0;
        m_err  = 1'b0;
        chk_idle_outputs("mid_reset");
        rst = 1'b0;
        run_txn(1'b0, 1'b0, {$urandom, $urandom}, '0, 8'h00, {$urandom, $urandom},
                {$urandom, $urandom}, 0, 0, 1'b0, 2'b00, 4);

        // Randomized traffic; latency checked when the slave is zero-wait.
        for (int n = 0; n < 24; n++) begin
            r_req  = 1'($urandom_range(0, 1));
            r_dev  = 1'($urandom_range(0, 1));
            r_addr = {$urandom, $urandom};
            r_wd   = {$urandom, $urandom, $urandom, $urandom};
            r_zw   = 1'($urandom_range(0, 1));
            r_ad   = r_zw ? 0 : int'($urandom_range(0, 3));
            r_rd   = r_zw ? 0 : int'($urandom_range(0, 3));
            r_tog  = r_zw ? 1'b0 : 1'($urandom_range(0, 1));
            if (!r_zw) r_lat = -1;
            else if (r_req) r_lat = r_dev ? -1 : 5;
            else r_lat = r_dev ? 3 : 4;
            run_txn(r_req, r_dev, r_addr, r_wd, 8'($urandom), {$urandom, $urandom},
                    {$urandom, $urandom}, r_ad, r_rd, r_tog, 2'b00, r_lat);
        end

        // SLVERR on a write, then OKAY traffic: err_o is sticky only with the check enabled.
        run_txn(1'b1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                8'h00, '0, '0, 0, 0, 1'b0, 2'b10, 5);
        chk("err_after_slverr", err, ErrEn);
        run_txn(1'b0, 1'b0, {$urandom, $urandom}, '0, 8'h00, {$urandom, $urandom},
                {$urandom, $urandom}, 0, 0, 1'b0, 2'b00, 4);
        run_txn(1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                8'hA5, '0, '0, 1, 0, 1'b1, 2'b00, -1);
        rst = 1'b1;
        @(negedge clk);
        m_data = '0;
        m_err  = 1'b0;
        chk_idle_outputs("final_reset");
        rst = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule

// File: doc/ysyx_220053_axi_bridge.md
Name: ysyx_220053_axi_bridge

Overview:
Downstream of the I/D-cache arbiter; converts the arbiter's single-request memory interface into AXI4 master transactions on a 64-bit data bus.
Cacheable requests become 2-beat INCR bursts that move one 128-bit line. Device (uncached) requests become single 64-bit beats with a byte strobe.
Completion uses a 4-phase valid/ready handshake back to the arbiter.

Parameters:
AXI_ADDR_W, 32, AXI address width; rw_addr_i[AXI_ADDR_W-1:0] is driven out.
AXI_ID, 4'd0, constant ARID/AWID value.

Ports:
clk  in  1  clock
rst  in  1  reset
rw_addr_i  in  64  request byte address
rw_req_i  in  1  1 = write, 0 = read
rw_valid_i  in  1  request valid, held until rw_ready_o seen
rw_w_data_i  in  128  write line; device writes use [63:0]
rw_size_i  in  8  device byte strobe (bit i = byte i of 64-bit word); ignored for line accesses
rw_dev_i  in  1  1 = device single beat, 0 = cache line burst
data_read_o  out  128  read result, registered
rw_ready_o  out  1  transaction complete
err_o  out  1  sticky AXI error flag (see Optional Feature)
axi_aw{valid,addr,id,len,size,burst}  out  AW channel (addr AXI_ADDR_W, id 4, len 8, size 3, burst 2)
axi_awready  in  1
axi_w{valid,data,strb,last}  out  1/64/8/1
axi_wready  in  1
axi_bvalid  in  1;  axi_bresp  in  2;  axi_bready  out  1
axi_ar{valid,addr,id,len,size,burst}  out  AR channel, same widths as AW
axi_arready  in  1
axi_rvalid  in  1;  axi_rdata  in  64;  axi_rresp  in  2;  axi_rlast  in  1;  axi_rready  out  1

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. All AXI valid/ready outputs, rw_ready_o, err_o, data_read_o and beat counter go to 0; state goes to IDLE. Reset mid-transaction aborts immediately; protocol completion is not required.
- States: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE. All AXI outputs are registered.
- IDLE: on rw_valid_i, latch addr/data/strobe/dev/req and go to RADDR (req=0) or WADDR (req=1).
- Address rules:
  - Line access: addr low 4 bits cleared, len=1, size=3, burst=INCR (2'b01).
  - Device access: addr as given (low 3 bits cleared), len=0, size=3, burst=INCR.
- RADDR: arvalid=1 until arready handshake, then RDATA.
- RDATA: rready=1. Each rvalid beat stores data into data_read_o[64*cnt +: 64]; cnt is a 1-bit counter incremented per beat. Leave RDATA on the beat where cnt==len (rlast is expected there). Device reads zero data_read_o[127:64].
- WADDR: awvalid=1 until awready, then WDATA (AW strictly before W).
- WDATA: wvalid=1.
  - Line access: beat0 = w_data[63:0], beat1 = [127:64], strb=8'hFF.
  - Device access: one beat with strb = latched rw_size_i.
  - wlast=1 on the final beat. After the final wready handshake go to WRESP.
- WRESP: bready=1 until bvalid, then DONE.
- DONE: rw_ready_o=1, held while rw_valid_i=1. When rw_valid_i=0, return to IDLE with rw_ready_o=0 on the next edge. No new request is accepted in the DONE cycle.
- data_read_o holds its value until the next read completes; writes do not modify it.
- Minimum latencies, counted from the edge sampling rw_valid_i=1 in IDLE, with zero-wait slave:
  - Line read: rw_ready_o high 4 cycles later.
  - Device read: 3 cycles.
  - Line write: 5 cycles.
- rw_valid_i dropping before DONE is a requester error; the transaction still completes.

Optional Feature:
YSYX_220053_AXI_RESP_CHECK_EN
- Defined:
  - err_o is set and held until rst when any rresp or bresp != 2'b00.
  - err_o is also set if rlast does not match the final beat.
  - Transactions still complete normally.
- Undefined: err_o is tied 0; resp and rlast are ignored.

Test Plan:
1. Line read, addr 0x8000_0018, slave returns 0x1111_1111_1111_1111 then 0x2222_2222_2222_2222, zero wait -> araddr=0x8000_0010, arlen=1; data_read_o=0x2222..2222_1111..1111; rw_ready_o high 4 cycles after request.
2. Device write, addr 0xA000_03F8, size 8'h0F, data[63:0]=0xDEAD_BEEF -> single beat: awlen=0, wstrb=8'h0F, wlast=1; rw_ready_o held until rw_valid_i drops, then IDLE.
3. Line write with awready delayed 3 cycles and wready toggling -> AW completes before any wvalid; two beats in order with wlast only on beat 2; one bready handshake.
4. Device read with rvalid delayed 5 cycles -> rready held high throughout; data_read_o[127:64]=0.
5. Reset asserted while in RDATA after beat0 -> next edge: all AXI valid/ready outputs and rw_ready_o = 0, state IDLE; a new request then completes normally.
6. With YSYX_220053_AXI_RESP_CHECK_EN: bresp=2'b10 on a write -> err_o=1 and stays 1 across further OKAY transactions until rst. Without the macro, err_o stays 0.
